bubble_sort_ram: RTL and testbench
==================================

Name: bubble_sort_ram

Overview:
- 32x8 register memory that is loaded externally, then sorted in place into ascending unsigned order by an in-place bubble-sort FSM.
- Sits directly upstream of the binary-search block.
- Its read port (raddr/dout) drives the searcher's address/data pair (addo -> raddr, dout -> din).
- Its done output tells the controller that the searcher may be started.

Parameters:
- N, 32, number of words; N >= 2.
- W, 8, word width in bits; compare is unsigned.
- AW, 5, address width; N <= 2^AW.

Ports:
- clock  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- s  input  1  start/hold; sort begins when sampled high in IDLE; done is held while s stays high.
- we  input  1  write enable for loading; honoured only in IDLE.
- waddr  input  AW  write address.
- wdata  input  W  write data.
- raddr  input  AW  read address.
- dout  output  W  combinational read data, mem[raddr].
- busy  output  1  high in SORT and CHECK.
- done  output  1  high in DONE.

Behaviour:
- Reset (synchronous): state=IDLE, all mem words=0, i=0, limit=N-2, swapped=0, busy=0, done=0. Applies mid-sort too; the interrupted sort is abandoned and memory is cleared.
- IDLE:
  - If we=1, mem[waddr]<=wdata.
  - If s=1, go to SORT with i=0, limit=N-2, swapped=0.
  - A write and s in the same cycle: the write lands and the sort includes it.
- SORT: one compare-swap per cycle on pair (i, i+1).
  - If mem[i] > mem[i+1] (strict, unsigned): swap both words at the edge and set swapped=1. Equal words are never swapped.
  - If i==limit, go to CHECK; otherwise i<=i+1.
- CHECK:
  - If swapped==0 or limit==0, go to DONE.
  - Otherwise limit<=limit-1, i<=0, swapped<=0, and go back to SORT.
- DONE: done=1; mem is frozen. Stay while s=1; go to IDLE when s=0. done falls the cycle after s is sampled low.
- Ignored inputs: we is ignored in SORT, CHECK and DONE. s is ignored in SORT and CHECK; dropping s mid-sort does not abort.
- dout is always mem[raddr], combinational and zero-latency, including mid-sort (in-flight contents). The searcher reads it only after done.
- Latency, counted in rising edges after the edge that samples s in IDLE, until done is high:
  - already sorted: N (32);
  - fully reversed: (N-2)(N-1)/2 + 2(N-1) (527 for N=32);
  - worst case is bounded by that value.
- Pass structure: pass p (limit=N-2-p) takes limit+1 compare cycles plus 1 CHECK cycle.
- Width rules: i and limit are AW bits wide; limit never decrements below 0, guaranteed by the CHECK exit.

Test Plan:
- Reset, then load mem[k]=k for k=0..31, pulse s high and keep it high -> busy=1 for edges 1..31 after the start edge, done=1 after edge 32; dout(raddr=k)=k for all k.
- Load mem[k]=31-k, s high -> done after exactly 527 edges; mem[k]=k; busy=0 while done=1.
- Load values {200,5,5,0,255,...} containing duplicates, 0 and 255 -> final memory is non-decreasing under unsigned compare (255 last, 0 first); duplicates are preserved in count.
- Mid-sort, drive we=1, waddr=3, wdata=8'hAA and drop s -> the write is ignored, sorting runs to completion, done rises and then drops one cycle later (s is low), state returns to IDLE.
- Assert reset 10 cycles into a reversed-data sort -> next cycle: busy=0, done=0, dout=0 for all addresses; a new load plus s then sorts correctly.
- After done, hold s and sweep raddr 0..31 feeding a binary-search model with target 8'h0F over data mem[k]=k -> found at address 15.

Source files
------------

// File: rtl/bubble_sort_ram.sv
// bubble_sort_ram
//   N x W register memory, loaded externally in IDLE, then sorted in place
//   into ascending unsigned order by a bubble-sort FSM. The read port feeds
//   the downstream binary searcher; done tells the controller the data is
//   ready to be searched.
//
// Ports
//   clock  : system clock, all state changes on the rising edge
//   reset  : synchronous active-high reset (clears memory, returns to IDLE)
//   s      : start in IDLE; holds DONE while high
//   we     : load write enable, honoured only in IDLE
//   waddr  : load write address
//   wdata  : load write data
//   raddr  : read address
//   dout   : combinational read data, mem[raddr]
//   busy   : high while sorting (SORT, CHECK)
//   done   : high in DONE
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | accept loads; wait for s
// SORT  | compare-swap pair (i, i+1); last pair of the pass is i == limit
// CHECK | end of pass: finish if no swaps or last pass, else shrink limit
// DONE  | memory frozen, done high until s is sampled low

module bubble_sort_ram #(
    parameter int N  = 32,
    parameter int W  = 8,
    parameter int AW = 5
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          s,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  dout,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SORT  = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [AW-1:0] LIMIT_INIT = AW'(N - 2);

    state_t state;
    state_t state_nxt;

    // Packed so the whole array clears with a single reset assignment.
    logic [N-1:0][W-1:0] mem;

    logic [AW-1:0] i;
    logic [AW-1:0] i_plus1;
    logic [AW-1:0] limit;
    logic          swapped;
    logic          need_swap;

    assign i_plus1   = i + AW'(1);
    // Strictly greater: equal words stay put.
    assign need_swap = mem[i] > mem[i_plus1];
    assign dout      = mem[raddr];

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (s) begin
                    state_nxt = SORT;
                end
            end
            SORT: begin
                busy = 1'b1;
                if (i == limit) begin
                    state_nxt = CHECK;
                end
            end
            CHECK: begin
                busy = 1'b1;
                // limit == 0 exit keeps limit from wrapping below zero.
                if (!swapped || limit == '0) begin
                    state_nxt = DONE;
                end else begin
                    state_nxt = SORT;
                end
            end
            DONE: begin
                done = 1'b1;
                if (!s) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            mem     <= '0;
            i       <= '0;
            limit   <= LIMIT_INIT;
            swapped <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (we) begin
                        mem[waddr] <= wdata;
                    end
                    if (s) begin
                        i       <= '0;
                        limit   <= LIMIT_INIT;
                        swapped <= 1'b0;
                    end
                end
                SORT: begin
                    if (need_swap) begin
                        mem[i]       <= mem[i_plus1];
                        mem[i_plus1] <= mem[i];
                        swapped      <= 1'b1;
                    end
                    if (i != limit) begin
                        i <= i_plus1;
                    end
                end
                CHECK: begin
                    if (swapped && limit != '0) begin
                        limit   <= limit - AW'(1);
                        i       <= '0;
                        swapped <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bubble_sort_ram.sv
module tb_bubble_sort_ram;

    localparam int N  = 32;
    localparam int W  = 8;
    localparam int AW = 5;
    localparam int TIMEOUT = 2000;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          s     = 1'b0;
    logic          we    = 1'b0;
    logic [AW-1:0] waddr = '0;
    logic [W-1:0]  wdata = '0;
    logic [AW-1:0] raddr = '0;
    logic [W-1:0]  dout;
    logic          busy;
    logic          done;

    int n_checks = 0;
    int n_fail   = 0;

    logic [W-1:0] dup_in  [N] = '{200, 5, 5, 0, 255, 17, 5, 128, 0, 255, 1, 2, 3, 99, 100, 101,
                                  7, 7, 64, 32, 16, 8, 4, 250, 251, 252, 128, 127, 129, 0, 9, 10};
    logic [W-1:0] dup_exp [N] = '{0, 0, 0, 1, 2, 3, 4, 5, 5, 5, 7, 7, 8, 9, 10, 16,
                                  17, 32, 64, 99, 100, 101, 127, 128, 128, 129, 200, 250, 251, 252, 255, 255};

    bubble_sort_ram #(.N(N), .W(W), .AW(AW)) dut (
        .clock (clock),
        .reset (reset),
        .s     (s),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .raddr (raddr),
        .dout  (dout),
        .busy  (busy),
        .done  (done)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic load_word(input int a, input logic [W-1:0] d);
        we    = 1'b1;
        waddr = AW'(a);
        wdata = d;
        tick();
        we    = 1'b0;
    endtask

    task automatic load_ramp(input bit reversed);
        for (int k = 0; k < N; k++) begin
            load_word(k, reversed ? W'(N - 1 - k) : W'(k));
        end
    endtask

    task automatic read_at(input int a, output logic [W-1:0] d);
        raddr = AW'(a);
        #1;
        d = dout;
    endtask

    // Returns the number of edges after the start edge until done is high.
    task automatic run_sort(output int lat, output bit busy_gap);
        int t;
        t        = 0;
        busy_gap = 1'b0;
        s        = 1'b1;
        do begin
            tick();
            t++;
            if (!done && !busy) busy_gap = 1'b1;
        end while (!done && t < TIMEOUT);
        lat = t - 1;
    endtask

    task automatic wait_done(output int t);
        t = 0;
        while (!done && t < TIMEOUT) begin
            tick();
            t++;
        end
    endtask

    task automatic check_ramp(input string tag);
        logic [W-1:0] d;
        for (int k = 0; k < N; k++) begin
            read_at(k, d);
            check(tag, 32'(d), k);
        end
    endtask

    initial begin
        int           lat;
        int           w;
        bit           gap;
        logic [W-1:0] d;
        logic [W-1:0] prev;
        int           lo;
        int           hi;
        int           mid;
        int           found;

        // Reset state
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        check("reset_busy", 32'(busy), 0);
        check("reset_done", 32'(done), 0);
        read_at(0, d);
        check("reset_mem0", 32'(d), 0);
        read_at(17, d);
        check("reset_mem17", 32'(d), 0);

        // Already sorted data
        load_ramp(1'b0);
        run_sort(lat, gap);
        check("sorted_latency", lat, 32);
        check("sorted_busy_gap", 32'(gap), 0);
        check("sorted_busy_at_done", 32'(busy), 0);
        check_ramp("sorted_dout");

        // Done holds while s high, then binary search over the frozen data
        tick();
        tick();
        check("done_hold", 32'(done), 1);
        lo    = 0;
        hi    = N - 1;
        found = -1;
        while (lo <= hi && found < 0) begin
            mid = (lo + hi) / 2;
            read_at(mid, d);
            if (d == 8'h0F) found = mid;
            else if (d < 8'h0F) lo = mid + 1;
            else hi = mid - 1;
        end
        check("search_0f_addr", found, 15);
        s = 1'b0;
        tick();
        check("done_release", 32'(done), 0);

        // Fully reversed data
        load_ramp(1'b1);
        run_sort(lat, gap);
        check("reversed_latency", lat, 527);
        check("reversed_busy_gap", 32'(gap), 0);
        check("reversed_busy_at_done", 32'(busy), 0);
        check_ramp("reversed_dout");
        s = 1'b0;
        tick();

        // Duplicates, zeros and 255s
        for (int k = 0; k < N; k++) load_word(k, dup_in[k]);
        run_sort(lat, gap);
        check("dup_latency_bound", 32'(lat <= 527), 1);
        prev = '0;
        for (int k = 0; k < N; k++) begin
            read_at(k, d);
            check("dup_dout", 32'(d), 32'(dup_exp[k]));
        end
        s = 1'b0;
        tick();

        // Write and s drop mid-sort are both ignored
        load_ramp(1'b1);
        s = 1'b1;
        for (int k = 0; k < 5; k++) tick();
        we    = 1'b1;
        waddr = AW'(3);
        wdata = 8'hAA;
        s     = 1'b0;
        for (int k = 0; k < 3; k++) tick();
        we = 1'b0;
        check("midsort_busy", 32'(busy), 1);
        wait_done(w);
        check("midsort_latency", 7 + w, 527);
        check("midsort_done", 32'(done), 1);
        check_ramp("midsort_dout");
        tick();
        check("midsort_done_fall", 32'(done), 0);
        check("midsort_idle_busy", 32'(busy), 0);

        // Reset in the middle of a reversed sort
        load_ramp(1'b1);
        s = 1'b1;
        for (int k = 0; k < 11; k++) tick();
        check("prereset_busy", 32'(busy), 1);
        reset = 1'b1;
        s     = 1'b0;
        tick();
        reset = 1'b0;
        check("midreset_busy", 32'(busy), 0);
        check("midreset_done", 32'(done), 0);
        for (int k = 0; k < N; k++) begin
            read_at(k, d);
            check("midreset_dout", 32'(d), 0);
        end
        load_ramp(1'b1);
        run_sort(lat, gap);
        check("resort_latency", lat, 527);
        check_ramp("resort_dout");
        s = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
